// File: rtl/cache_refill_responder_pkg.sv
// Shared types and address-field helpers for the cache refill responder.
// Address layout: tag [31:7], set [6], byte offset [5:0].
package cache_refill_responder_pkg;

  localparam int unsigned TAG_W    = 25;
  localparam int unsigned OFFSET_W = 6;
  localparam int unsigned WORD_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } refillState_t;

  function automatic logic [TAG_W-1:0] addrTag(input logic [31:0] addr);
    return addr[31:OFFSET_W+1];
  endfunction

  function automatic logic addrSet(input logic [31:0] addr);
    return addr[OFFSET_W];
  endfunction

endpackage

// File: rtl/cache_refill_responder_word_buffer.sv
// Refill assembly buffer: one word written per cycle by index, whole block
// presented flattened with word i at bits [32i+31:32i].
module refill_word_buffer
  import cache_refill_responder_pkg::*;
#(
  parameter int unsigned WORDS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wrEn,
  input  logic [$clog2(WORDS)-1:0]   wrIdx,
  input  logic [WORD_W-1:0]          wrData,
  output logic [WORD_W*WORDS-1:0]    block
);

  logic [WORD_W-1:0] words [WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WORDS; i++) words[i] <= '0;
    end else if (wrEn) begin
      words[wrIdx] <= wrData;
    end
  end

  always_comb begin
    block = '0;
    for (int unsigned i = 0; i < WORDS; i++) block[i*WORD_W +: WORD_W] = words[i];
  end

endmodule

// File: rtl/cache_refill_responder.sv
// Miss responder: optional dirty-victim writeback, then a word-by-word block
// fetch, returning the block with tag/set and a round-robin victim way.
module cache_refill_responder
  import cache_refill_responder_pkg::*;
#(
  parameter int unsigned WORDS     = 16,
  parameter int unsigned WAYS_LOG2 = 3,
  parameter int unsigned SETS      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic                      req_wb,
  input  logic [TAG_W-1:0]          req_wb_tag,
  input  logic [WORD_W*WORDS-1:0]   req_wb_block,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [WORD_W*WORDS-1:0]   resp_block,
  output logic [TAG_W-1:0]          resp_tag,
  output logic                      resp_set,
  output logic [WAYS_LOG2-1:0]      resp_way,
  output logic                      resp_valid_bit,
  output logic                      mem_cmd,
  output logic                      mem_we,
  output logic [31:0]               mem_addr,
  output logic [WORD_W-1:0]         mem_wdata,
  input  logic                      mem_ready,
  input  logic                      mem_rvalid,
  input  logic [WORD_W-1:0]         mem_rdata
);

  localparam int unsigned CNT_W = $clog2(WORDS);

  refillState_t               state, stateNext;
  logic [CNT_W-1:0]           cnt;
  logic                       cntLast;
  logic [TAG_W-1:0]           tagQ, wbTagQ;
  logic                       setQ;
  logic [WAYS_LOG2-1:0]       wayQ;
  logic [WORD_W*WORDS-1:0]    wbBlockQ;
  logic [WAYS_LOG2-1:0]       rrPtr [SETS];
  logic                       bufWrEn;

  assign cntLast  = (cnt == CNT_W'(WORDS - 1));
  assign resp_tag = tagQ;
  assign resp_set = setQ;
  assign resp_way = wayQ;

  always_comb begin
    stateNext      = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_valid_bit = 1'b0;
    mem_cmd        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    bufWrEn        = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) stateNext = req_wb ? WB : RD_ISSUE;
      end
      WB: begin
        mem_cmd   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wbTagQ, setQ, cnt, 2'b00};
        mem_wdata = wbBlockQ[cnt*WORD_W +: WORD_W];
        if (mem_ready && cntLast) stateNext = RD_ISSUE;
      end
      RD_ISSUE: begin
        mem_cmd  = 1'b1;
        mem_addr = {tagQ, setQ, cnt, 2'b00};
        if (mem_ready) stateNext = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          bufWrEn   = 1'b1;
          stateNext = cntLast ? RESP : RD_ISSUE;
        end
      end
      RESP: begin
        resp_valid     = 1'b1;
        resp_valid_bit = 1'b1;
        if (resp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      tagQ     <= '0;
      setQ     <= 1'b0;
      wayQ     <= '0;
      wbTagQ   <= '0;
      wbBlockQ <= '0;
      for (int unsigned s = 0; s < SETS; s++) rrPtr[s] <= '0;
    end else begin
      state <= stateNext;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            tagQ     <= addrTag(req_addr);
            setQ     <= addrSet(req_addr);
            wayQ     <= rrPtr[addrSet(req_addr)];
            wbTagQ   <= req_wb_tag;
            wbBlockQ <= req_wb_block;
            cnt      <= '0;
          end
        end
        WB:      if (mem_ready)  cnt <= cntLast ? '0 : cnt + 1'b1;
        RD_WAIT: if (mem_rvalid) cnt <= cntLast ? '0 : cnt + 1'b1;
        RESP:    if (resp_ready) rrPtr[setQ] <= rrPtr[setQ] + 1'b1;
        default: ;
      endcase
    end
  end

  refill_word_buffer #(.WORDS(WORDS)) wordBuffer (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (bufWrEn),
    .wrIdx  (cnt),
    .wrData (mem_rdata),
    .block  (resp_block)
  );

endmodule

// File: tb/tb_cache_refill_responder.sv
// Directed bench for cache_refill_responder with a latency/stall-programmable
// memory model driven on the falling clock edge.
module tb_cache_refill_responder;
  import cache_refill_responder_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         req_wb = 1'b0;
  logic [24:0]  req_wb_tag = '0;
  logic [511:0] req_wb_block = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [511:0] resp_block;
  logic [24:0]  resp_tag;
  logic         resp_set;
  logic [2:0]   resp_way;
  logic         resp_valid_bit;
  logic         mem_cmd;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready = 1'b1;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;

  always #5 clk = ~clk;

  cache_refill_responder #(.WORDS(16), .WAYS_LOG2(3), .SETS(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wb(req_wb), .req_wb_tag(req_wb_tag), .req_wb_block(req_wb_block),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_block(resp_block),
    .resp_tag(resp_tag), .resp_set(resp_set), .resp_way(resp_way),
    .resp_valid_bit(resp_valid_bit),
    .mem_cmd(mem_cmd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Memory model state; each variable has a single writing process.
  logic [31:0] logAddr [$];
  logic        logWe   [$];
  logic [31:0] logData [$];
  logic [31:0] holdAddr [$];
  logic        holdCmd  [$];
  int unsigned lat [16];
  logic [31:0] stallAddr = '1;
  int          stallTarget = 0;
  int          stallDone = 0;
  int          spurReq = 0;
  int          spurDone = 0;
  int          rdDelivered = 0;
  logic        pending = 1'b0;
  logic [31:0] pendAddr = '0;
  int unsigned cd = 0;

  function automatic logic [31:0] memVal(input logic [31:0] a);
    return (a ^ 32'h5EED_F00D) + {a[7:0], 24'h0};
  endfunction

  function automatic logic [511:0] expBlock(input logic [31:0] base);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = memVal(base + 32'(4*i));
    return b;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (reset) begin
        pending = 1'b0;
      end else if (spurDone != spurReq) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        spurDone   = spurReq;
      end else if (pending) begin
        if (cd <= 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = memVal(pendAddr);
          pending    = 1'b0;
          rdDelivered++;
        end else begin
          cd--;
        end
      end
      mem_ready = 1'b1;
      if (!reset && mem_addr == stallAddr && stallDone < stallTarget) begin
        mem_ready = 1'b0;
        stallDone++;
        holdAddr.push_back(mem_addr);
        holdCmd.push_back(mem_cmd);
      end else if (!reset && mem_cmd === 1'b1) begin
        logAddr.push_back(mem_addr);
        logWe.push_back(mem_we);
        logData.push_back(mem_wdata);
        if (!mem_we) begin
          pending  = 1'b1;
          pendAddr = mem_addr;
          cd       = lat[mem_addr[5:2]];
        end
      end
    end
  end

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic startReq(input logic [31:0] addr, input logic wb,
                          input logic [24:0] wbTag, input logic [511:0] wbBlk);
    @(negedge clk);
    nChecks++;
    if (req_ready !== 1'b1) begin
      nFails++;
      $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; req_addr = addr; req_wb = wb;
    req_wb_tag = wbTag; req_wb_block = wbBlk;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitResp(output int cycles);
    cycles = 1;
    while (resp_valid !== 1'b1 && cycles < 400) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    if (resp_valid !== 1'b1) begin
      nChecks++; nFails++;
      $display("FAIL resp_timeout: got resp_valid=%b after %0d cycles expected 1", resp_valid, cycles);
    end
  endtask

  task automatic acceptResp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    nChecks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      nFails++;
      $display("FAIL resp_handshake: got valid/ready=%b expected 01", {resp_valid, req_ready});
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({req_ready, resp_valid, mem_cmd, resp_tag, resp_set, resp_way} !== {1'b1, 1'b0, 1'b0, 25'h0, 1'b0, 3'd0}) begin
      nFails++;
      $display("FAIL reset_ctrl: got rdy=%b val=%b cmd=%b tag=%h set=%b way=%0d expected 1 0 0 0 0 0",
               req_ready, resp_valid, mem_cmd, resp_tag, resp_set, resp_way);
    end
    nChecks++;
    if (resp_block !== 512'h0) begin
      nFails++;
      $display("FAIL reset_block: got %h expected 0", resp_block);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_miss();
    int cyc;
    int b;
    b = logAddr.size();
    startReq(32'h0000_1040, 1'b0, '0, '0);
    waitResp(cyc);
    nChecks++;
    if (cyc !== 33) begin nFails++; $display("FAIL clean_latency: got %0d expected 33", cyc); end
    nChecks++;
    if ({resp_tag, resp_set, resp_way, resp_valid_bit} !== {25'h20, 1'b1, 3'd0, 1'b1}) begin
      nFails++;
      $display("FAIL clean_fields: got tag=%h set=%b way=%0d vb=%b expected 20 1 0 1", resp_tag, resp_set, resp_way, resp_valid_bit);
    end
    nChecks++;
    if (resp_block !== expBlock(32'h1040)) begin nFails++; $display("FAIL clean_block: got %h expected %h", resp_block, expBlock(32'h1040)); end
    nChecks++;
    if (logAddr.size() - b !== 16) begin nFails++; $display("FAIL clean_cmd_count: got %0d expected 16", logAddr.size() - b); end
    for (int i = 0; i < 16; i++) begin
      nChecks++;
      if ({logWe[b+i], logAddr[b+i]} !== {1'b0, 32'h1040 + 32'(4*i)}) begin
        nFails++;
        $display("FAIL clean_read_%0d: got we=%b addr=%h expected 0 %h", i, logWe[b+i], logAddr[b+i], 32'h1040 + 32'(4*i));
      end
    end
    acceptResp();
  endtask

  task automatic test_dirty_miss();
    int cyc;
    int b;
    logic [511:0] vic;
    for (int i = 0; i < 16; i++) vic[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
    b = logAddr.size();
    startReq(32'h0000_2000, 1'b1, 25'h1ABCDEF, vic);
    waitResp(cyc);
    nChecks++;
    if (cyc !== 49) begin nFails++; $display("FAIL dirty_latency: got %0d expected 49", cyc); end
    nChecks++;
    if (logAddr.size() - b !== 32) begin nFails++; $display("FAIL dirty_cmd_count: got %0d expected 32", logAddr.size() - b); end
    for (int i = 0; i < 16; i++) begin
      nChecks++;
      if ({logWe[b+i], logAddr[b+i], logData[b+i]} !== {1'b1, 32'hD5E6_F780 + 32'(4*i), 32'hA5A5_0000 + 32'(i)}) begin
        nFails++;
        $display("FAIL dirty_write_%0d: got we=%b addr=%h data=%h expected 1 %h %h", i, logWe[b+i], logAddr[b+i],
                 logData[b+i], 32'hD5E6_F780 + 32'(4*i), 32'hA5A5_0000 + 32'(i));
      end
      nChecks++;
      if ({logWe[b+16+i], logAddr[b+16+i]} !== {1'b0, 32'h2000 + 32'(4*i)}) begin
        nFails++;
        $display("FAIL dirty_read_%0d: got we=%b addr=%h expected 0 %h", i, logWe[b+16+i], logAddr[b+16+i], 32'h2000 + 32'(4*i));
      end
    end
    nChecks++;
    if ({resp_tag, resp_set, resp_way} !== {25'h40, 1'b0, 3'd0}) begin
      nFails++;
      $display("FAIL dirty_fields: got tag=%h set=%b way=%0d expected 40 0 0", resp_tag, resp_set, resp_way);
    end
    nChecks++;
    if (resp_block !== expBlock(32'h2000)) begin nFails++; $display("FAIL dirty_block: got %h expected %h", resp_block, expBlock(32'h2000)); end
    acceptResp();
  endtask

  task automatic test_round_robin();
    int cyc;
    applyReset();
    for (int k = 0; k < 9; k++) begin
      startReq(32'h0001_0000 + 32'(k*128), 1'b0, '0, '0);
      waitResp(cyc);
      nChecks++;
      if (resp_way !== 3'(k % 8)) begin nFails++; $display("FAIL rr_way_set0_%0d: got %0d expected %0d", k, resp_way, k % 8); end
      acceptResp();
    end
    startReq(32'h0001_0040, 1'b0, '0, '0);
    waitResp(cyc);
    nChecks++;
    if ({resp_set, resp_way} !== {1'b1, 3'd0}) begin nFails++; $display("FAIL rr_way_set1: got set=%b way=%0d expected 1 0", resp_set, resp_way); end
    acceptResp();
  endtask

  task automatic test_backpressure();
    int cyc;
    int b;
    int hb;
    b  = logAddr.size();
    hb = holdAddr.size();
    stallAddr   = 32'h0000_300C;
    stallTarget = stallDone + 5;
    startReq(32'h0000_3000, 1'b0, '0, '0);
    waitResp(cyc);
    nChecks++;
    if (cyc !== 38) begin nFails++; $display("FAIL bp_latency: got %0d expected 38", cyc); end
    nChecks++;
    if (holdAddr.size() - hb !== 5) begin nFails++; $display("FAIL bp_stall_count: got %0d expected 5", holdAddr.size() - hb); end
    for (int i = hb; i < holdAddr.size(); i++) begin
      nChecks++;
      if ({holdCmd[i], holdAddr[i]} !== {1'b1, 32'h300C}) begin
        nFails++;
        $display("FAIL bp_hold_%0d: got cmd=%b addr=%h expected 1 0000300c", i - hb, holdCmd[i], holdAddr[i]);
      end
    end
    nChecks++;
    if (logAddr.size() - b !== 16) begin nFails++; $display("FAIL bp_cmd_count: got %0d expected 16", logAddr.size() - b); end
    for (int i = 0; i < 16; i++) begin
      nChecks++;
      if (logAddr[b+i] !== 32'h3000 + 32'(4*i)) begin
        nFails++;
        $display("FAIL bp_read_%0d: got %h expected %h", i, logAddr[b+i], 32'h3000 + 32'(4*i));
      end
    end
    // rr[0] was left at 1 by the round-robin sequence.
    for (int c = 0; c < 10; c++) begin
      nChecks++;
      if ({resp_valid, resp_tag, resp_set, resp_way} !== {1'b1, 25'h60, 1'b0, 3'd1} || resp_block !== expBlock(32'h3000)) begin
        nFails++;
        $display("FAIL bp_resp_hold_%0d: got val=%b tag=%h set=%b way=%0d expected 1 60 0 1 block ok=%b",
                 c, resp_valid, resp_tag, resp_set, resp_way, resp_block === expBlock(32'h3000));
      end
      @(negedge clk);
    end
    acceptResp();
    stallAddr = '1;
  endtask

  task automatic test_variable_latency();
    int cyc;
    for (int i = 0; i < 16; i++) lat[i] = (i % 3 == 0) ? 1 : (i % 3 == 1) ? 4 : 7;
    startReq(32'h0000_4040, 1'b0, '0, '0);
    waitResp(cyc);
    nChecks++;
    if (cyc !== 78) begin nFails++; $display("FAIL varlat_latency: got %0d expected 78", cyc); end
    nChecks++;
    if (resp_block !== expBlock(32'h4040)) begin nFails++; $display("FAIL varlat_block: got %h expected %h", resp_block, expBlock(32'h4040)); end
    spurReq++;
    repeat (3) @(negedge clk);
    nChecks++;
    if (resp_valid !== 1'b1 || resp_block !== expBlock(32'h4040)) begin
      nFails++;
      $display("FAIL spurious_rvalid: got val=%b block %h expected 1 %h", resp_valid, resp_block, expBlock(32'h4040));
    end
    nChecks++;
    if ({resp_tag, resp_set, resp_way} !== {25'h80, 1'b1, 3'd1}) begin
      nFails++;
      $display("FAIL varlat_fields: got tag=%h set=%b way=%0d expected 80 1 1", resp_tag, resp_set, resp_way);
    end
    acceptResp();
    for (int i = 0; i < 16; i++) lat[i] = 1;
  endtask

  task automatic test_reset_mid_fetch();
    int cyc;
    int b;
    int waited;
    applyReset();
    startReq(32'h0000_5000, 1'b0, '0, '0);
    waitResp(cyc);
    acceptResp();
    b = rdDelivered;
    startReq(32'h0000_5080, 1'b0, '0, '0);
    waited = 0;
    while (rdDelivered - b < 8 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    nChecks++;
    if (rdDelivered - b < 8) begin nFails++; $display("FAIL midreset_progress: got %0d words expected 8", rdDelivered - b); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({req_ready, resp_valid, mem_cmd} !== 3'b100 || resp_block !== 512'h0) begin
      nFails++;
      $display("FAIL midreset_idle: got rdy=%b val=%b cmd=%b block_zero=%b expected 1 0 0 1",
               req_ready, resp_valid, mem_cmd, resp_block === 512'h0);
    end
    reset = 1'b0;
    b = logAddr.size();
    startReq(32'h0000_5100, 1'b0, '0, '0);
    waitResp(cyc);
    nChecks++;
    if (cyc !== 33) begin nFails++; $display("FAIL midreset_latency: got %0d expected 33", cyc); end
    nChecks++;
    if (resp_way !== 3'd0) begin nFails++; $display("FAIL midreset_rr: got way=%0d expected 0", resp_way); end
    nChecks++;
    if (resp_block !== expBlock(32'h5100)) begin nFails++; $display("FAIL midreset_block: got %h expected %h", resp_block, expBlock(32'h5100)); end
    nChecks++;
    if (logAddr.size() - b !== 16 || logAddr[b] !== 32'h5100) begin
      nFails++;
      $display("FAIL midreset_reads: got count=%0d first=%h expected 16 00005100", logAddr.size() - b, logAddr[b]);
    end
    acceptResp();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lat[i] = 1;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_round_robin();
    test_backpressure();
    test_variable_latency();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
